lfsr_stream_cipher: RTL and testbench

- Parametrised keystream engine for the crypto datapath.
- Accepts a burst of message words on a valid/ready input and XORs each word with a Galois-LFSR keystream word.
- Emits results through a registered valid/ready output stage and pulses done at burst end.
- Successor to the fixed 32-bit single-bit-out message core: configurable width, burst length, backpressure, and a bypass mode.

---
 rtl/lfsr_stream_cipher.sv | 66 ++++++
 tb/tb_lfsr_stream_cipher.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_stream_cipher.sv
// lfsr_stream_cipher: XORs a burst of message words with a Galois-LFSR keystream behind a registered valid/ready output
module lfsr_stream_cipher #(
  parameter int DATA_W = 32,
  parameter logic [DATA_W-1:0] POLY = DATA_W'(32'hEDB88320),
  parameter int LEN_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] seed,
  input  logic [LEN_W-1:0]  len,
  input  logic              bypass,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  input  logic              out_ready,
  output logic              busy,
  output logic              done
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t state, state_nx;
  logic [DATA_W-1:0] lfsr;
  logic [LEN_W-1:0] remaining;
  logic mode, accept, last_word, start_ok, start_empty, finish;
  assign start_ok    = (state == IDLE) && start && (len != '0);
  assign start_empty = (state == IDLE) && start && (len == '0);
  assign in_ready    = (state == RUN) && (remaining != '0) && (!out_valid || out_ready);
  assign accept      = in_valid && in_ready;
  assign last_word   = remaining == LEN_W'(1);
  assign finish      = (state == DRAIN) && out_valid && out_last && out_ready;
  assign busy        = state != IDLE;
  always_comb begin
    state_nx = start_ok ? RUN : (accept && last_word) ? DRAIN : finish ? IDLE : state;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      lfsr      <= '0;
      remaining <= '0;
      mode      <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_nx;
      done      <= start_empty || finish;
      out_valid <= accept || (out_valid && !out_ready);
      if (start_ok) begin
        lfsr      <= seed;
        remaining <= len;
        mode      <= bypass;
      end
      if (accept) begin
        out_data  <= in_data ^ (mode ? '0 : lfsr);
        out_last  <= last_word;
        remaining <= remaining - LEN_W'(1);
        // keystream only moves forward when it was actually consumed
        if (!mode) lfsr <= (lfsr >> 1) ^ (lfsr[0] ? POLY : '0);
      end
    end
  end
endmodule

// File: tb/tb_lfsr_stream_cipher.sv
// tb_lfsr_stream_cipher: randomized bursts checked against a keystream-table reference model
module tb_lfsr_stream_cipher;
  localparam logic [31:0] POLY = 32'hEDB88320;
  logic clk = 1'b0;
  logic reset, start, bypass, in_valid, out_ready;
  logic [31:0] seed, in_data;
  logic [7:0] len;
  logic in_ready, out_valid, out_last, busy, done;
  logic [31:0] out_data;
  logic [31:0] msg[$], res[$], orig[$];
  int vectors = 0, miscompares = 0;

  always #5 clk = ~clk;

  lfsr_stream_cipher #(.DATA_W(32), .POLY(POLY), .LEN_W(8)) dut (
    .clk(clk), .reset(reset), .start(start), .seed(seed), .len(len), .bypass(bypass),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
    .busy(busy), .done(done)
  );

  function automatic logic [31:0] advance(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? POLY : 32'h0);
  endfunction

  // rdy_mode: 0 always ready, 1 pattern 1,0,0, 2 random; iv_rand: random in_valid gaps
  task automatic run_burst(input logic [31:0] sd, input int n, input logic byp,
                           input int rdy_mode, input bit iv_rand, input bit mid_start);
    logic [31:0] exp_q[$];
    logic [31:0] k, prev_data;
    int sent, outs, cyc;
    bit prev_stall;
    k = sd;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(msg[i] ^ (byp ? 32'h0 : k));
      if (!byp) k = advance(k);
    end
    res.delete();
    @(negedge clk);
    start = 1'b1; seed = sd; len = 8'(n); bypass = byp; in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1;
    if (busy !== 1'b1) begin $display("FAIL busy_after_start got %b exp 1", busy); miscompares++; end
    vectors++;
    sent = 0; outs = 0; cyc = 0; prev_stall = 0; prev_data = '0;
    while (outs < n && cyc < 400) begin
      if (cyc != 0) @(negedge clk);
      start = mid_start && (cyc == 2);
      seed = start ? $urandom : sd;
      len = start ? 8'd3 : 8'(n);
      in_valid = iv_rand ? ((sent < n) && $urandom_range(0, 1) == 1) : 1'b1;
      in_data = (sent < n) ? msg[sent] : $urandom;
      out_ready = rdy_mode == 0 ? 1'b1 : rdy_mode == 1 ? (cyc % 3 == 0) : $urandom_range(0, 1) == 1;
      #1;
      if (prev_stall) begin
        if (out_valid !== 1'b1 || out_data !== prev_data) begin
          $display("FAIL stall_hold got v=%b d=%h exp v=1 d=%h", out_valid, out_data, prev_data); miscompares++;
        end
        vectors++;
      end
      if (out_valid && !out_ready) begin
        if (in_ready !== 1'b0) begin $display("FAIL in_ready_stall got %b exp 0", in_ready); miscompares++; end
        vectors++;
      end
      if (sent >= n) begin
        if (in_ready !== 1'b0) begin $display("FAIL in_ready_after_len got %b exp 0", in_ready); miscompares++; end
        vectors++;
      end
      if (done !== 1'b0) begin $display("FAIL done_early got %b exp 0", done); miscompares++; end
      vectors++;
      if (out_valid && out_ready) begin
        if (out_data !== exp_q[outs]) begin
          $display("FAIL out_data[%0d] got %h exp %h", outs, out_data, exp_q[outs]); miscompares++;
        end
        if (out_last !== (outs == n - 1)) begin
          $display("FAIL out_last[%0d] got %b exp %b", outs, out_last, outs == n - 1); miscompares++;
        end
        vectors += 2;
        res.push_back(out_data);
        outs++;
      end
      if (in_valid && in_ready) sent++;
      prev_stall = out_valid && !out_ready;
      prev_data = out_data;
      cyc++;
    end
    start = 1'b0;
    if (outs != n || sent != n) begin $display("FAIL word_count got out=%0d in=%0d exp %0d", outs, sent, n); miscompares++; end
    vectors++;
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    #1;
    if (done !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
      $display("FAIL burst_end got done=%b busy=%b ov=%b exp 1 0 0", done, busy, out_valid); miscompares++;
    end
    vectors++;
    @(negedge clk);
    #1;
    if (done !== 1'b0) begin $display("FAIL done_width got %b exp 0", done); miscompares++; end
    vectors++;
  endtask

  task automatic test_reset;
    reset = 1'b0; start = 1'b0; seed = '0; len = '0; bypass = 1'b0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    if ({out_valid, out_last, done, busy, in_ready} !== 5'b0 || out_data !== 32'h0) begin
      $display("FAIL reset_state got v=%b l=%b d=%b b=%b r=%b data=%h exp all 0",
               out_valid, out_last, done, busy, in_ready, out_data); miscompares++;
    end
    vectors++;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_keystream;
    msg = '{32'h0, 32'h0, 32'h0};
    run_burst(32'h1, 3, 1'b0, 0, 1'b0, 1'b0);
    orig = '{32'h00000001, 32'hEDB88320, 32'h76DC4190};
    for (int i = 0; i < 3; i++) begin
      if (res.size() <= i || res[i] !== orig[i]) begin
        $display("FAIL keystream[%0d] got %h exp %h", i, res.size() > i ? res[i] : 32'hx, orig[i]); miscompares++;
      end
      vectors++;
    end
  endtask

  task automatic test_round_trip;
    msg.delete();
    for (int i = 0; i < 4; i++) msg.push_back($urandom);
    orig = msg;
    run_burst(32'hCAFEF00D, 4, 1'b0, 2, 1'b1, 1'b0);
    msg = res;
    run_burst(32'hCAFEF00D, 4, 1'b0, 2, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      if (res.size() <= i || res[i] !== orig[i]) begin
        $display("FAIL round_trip[%0d] got %h exp %h", i, res.size() > i ? res[i] : 32'hx, orig[i]); miscompares++;
      end
      vectors++;
    end
  endtask

  task automatic test_backpressure;
    msg.delete();
    for (int i = 0; i < 5; i++) msg.push_back($urandom);
    run_burst($urandom, 5, 1'b0, 1, 1'b0, 1'b0);
    if (res.size() != 5) begin $display("FAIL bp_count got %0d exp 5", res.size()); miscompares++; end
    vectors++;
  endtask

  task automatic test_bypass;
    msg = '{32'h12345678, 32'h9ABCDEF0};
    run_burst(32'h1, 2, 1'b1, 0, 1'b0, 1'b0);
    msg = '{32'h0, 32'h0};
    run_burst(32'h1, 2, 1'b0, 0, 1'b0, 1'b0);
    if (res.size() < 1 || res[0] !== 32'h1) begin
      $display("FAIL post_bypass_key got %h exp 00000001", res.size() > 0 ? res[0] : 32'hx); miscompares++;
    end
    vectors++;
  endtask

  task automatic test_edge_starts;
    @(negedge clk);
    start = 1'b1; len = 8'd0; seed = $urandom;
    #1;
    if (busy !== 1'b0 || done !== 1'b0) begin $display("FAIL len0_req got busy=%b done=%b exp 0 0", busy, done); miscompares++; end
    vectors++;
    @(negedge clk);
    start = 1'b0;
    #1;
    if (busy !== 1'b0 || done !== 1'b1) begin $display("FAIL len0_done got busy=%b done=%b exp 0 1", busy, done); miscompares++; end
    vectors++;
    @(negedge clk);
    #1;
    if (busy !== 1'b0 || done !== 1'b0) begin $display("FAIL len0_after got busy=%b done=%b exp 0 0", busy, done); miscompares++; end
    vectors++;
    msg.delete();
    for (int i = 0; i < 6; i++) msg.push_back($urandom);
    run_burst($urandom, 6, 1'b0, 2, 1'b1, 1'b1);
  endtask

  task automatic test_reset_mid_burst;
    int sent, cyc;
    @(negedge clk);
    start = 1'b1; seed = $urandom; len = 8'd4; bypass = 1'b0;
    @(negedge clk);
    start = 1'b0; out_ready = 1'b1;
    sent = 0; cyc = 0;
    while (sent < 2 && cyc < 50) begin
      if (cyc != 0) @(negedge clk);
      in_valid = 1'b1; in_data = $urandom;
      #1;
      if (in_ready) sent++;
      cyc++;
    end
    if (sent != 2) begin $display("FAIL rst_feed got %0d exp 2", sent); miscompares++; end
    vectors++;
    @(negedge clk);
    in_valid = 1'b0; reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    if ({out_valid, busy, in_ready, done} !== 4'b0) begin
      $display("FAIL rst_mid got v=%b b=%b r=%b d=%b exp 0 0 0 0", out_valid, busy, in_ready, done); miscompares++;
    end
    vectors++;
    msg = '{32'h0};
    run_burst(32'h1, 1, 1'b0, 0, 1'b0, 1'b0);
    if (res.size() < 1 || res[0] !== 32'h1) begin
      $display("FAIL rst_restart got %h exp 00000001", res.size() > 0 ? res[0] : 32'hx); miscompares++;
    end
    vectors++;
  endtask

  task automatic test_random;
    int n;
    for (int t = 0; t < 6; t++) begin
      n = $urandom_range(1, 12);
      msg.delete();
      for (int i = 0; i < n; i++) msg.push_back($urandom);
      run_burst($urandom, n, $urandom_range(0, 3) == 0, 2, 1'b1, 1'b0);
    end
  endtask

  initial begin
    test_reset;
    test_keystream;
    test_round_trip;
    test_backpressure;
    test_bypass;
    test_edge_starts;
    test_reset_mid_burst;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
